// File: rtl/bram_rr_arbiter_if.sv
// Requester-side handshake for bram_rr_arbiter: one read or one write per cycle,
// held until granted, with read data returned on rvalid one cycle after the grant.
interface bram_rr_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_rr_arbiter.sv
// Shares one simple-dual-port BRAM between requesters A and B with independent read/write
// round-robin. Defining BRAM_ARB_CLEAR_EN adds a zero-fill sweep of every word after reset.
module bram_rr_arbiter #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 131072
) (
  input  logic              clk,
  input  logic              reset,
  bram_rr_arbiter_if.slave  a,
  bram_rr_arbiter_if.slave  b,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              clear_busy
);

  logic              run_c;
  logic              clearing_c;
  logic              a_rd_c, a_wr_c, b_rd_c, b_wr_c;
  logic              rd_ptr_q, wr_ptr_q;     // 1 = B wins the next contested grant
  logic              rd_win_b_c, wr_win_b_c;
  logic              rd_gnt_c, wr_gnt_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [ADDR_W-1:0] clr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              rd_vld_q, rd_own_q, rd_oor_q;
  logic              a_rv_c, b_rv_c;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 64'(addr) < 64'(DEPTH);
  endfunction

`ifdef BRAM_ARB_CLEAR_EN
  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (cnt_q == CNT_LAST) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Sweep address; a reset mid-sweep restarts it from word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   cnt_q <= '0;
    else if (state_q == ST_CLEAR) cnt_q <= cnt_q + CNT_W'(1);
  end

  always_comb begin
    clearing_c = (state_q == ST_CLEAR);
    clear_busy = clearing_c;
    clr_addr_c = ADDR_W'(cnt_q);
  end
`else
  always_comb begin
    clearing_c = 1'b0;
    clear_busy = 1'b0;
    clr_addr_c = '0;
  end
`endif

  // Request decode and per-port winner selection
  always_comb begin
    run_c      = reset & ~clearing_c;
    a_rd_c     = a.req & ~a.we;
    a_wr_c     = a.req &  a.we;
    b_rd_c     = b.req & ~b.we;
    b_wr_c     = b.req &  b.we;
    rd_win_b_c = b_rd_c & (~a_rd_c | rd_ptr_q);
    wr_win_b_c = b_wr_c & (~a_wr_c | wr_ptr_q);
    rd_gnt_c   = run_c & (a_rd_c | b_rd_c);
    wr_gnt_c   = run_c & (a_wr_c | b_wr_c);
  end

  always_comb begin
    a.gnt = run_c & ((a_rd_c & ~rd_win_b_c) | (a_wr_c & ~wr_win_b_c));
    b.gnt = run_c & ((b_rd_c &  rd_win_b_c) | (b_wr_c &  wr_win_b_c));
  end

  // Out-of-range writes are granted but never reach the memory
  always_comb begin
    mem_raddr = rd_win_b_c ? b.addr  : a.addr;
    wr_addr_c = wr_win_b_c ? b.addr  : a.addr;
    wr_data_c = wr_win_b_c ? b.wdata : a.wdata;
    mem_waddr = wr_addr_c;
    mem_din   = wr_data_c;
    mem_we    = wr_gnt_c & in_range(wr_addr_c);
    if (clearing_c) begin
      mem_waddr = clr_addr_c;
      mem_din   = '0;
      mem_we    = reset;
    end
  end

  // Pointer hands priority to the loser only when both contend for the port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (run_c) begin
      if (a_rd_c & b_rd_c) rd_ptr_q <= ~rd_ptr_q;
      if (a_wr_c & b_wr_c) wr_ptr_q <= ~wr_ptr_q;
    end
  end

  // Tag travels alongside the BRAM's one-cycle read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_gnt_c;
      rd_own_q <= rd_win_b_c;
      rd_oor_q <= ~in_range(mem_raddr);
    end
  end

  always_comb begin
    a_rv_c   = rd_vld_q & ~rd_own_q;
    b_rv_c   = rd_vld_q &  rd_own_q;
    a.rvalid = a_rv_c;
    b.rvalid = b_rv_c;
    a.rdata  = (a_rv_c & ~rd_oor_q) ? mem_dout : '0;
    b.rdata  = (b_rv_c & ~rd_oor_q) ? mem_dout : '0;
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench for bram_rr_arbiter: directed vector table, reset/clear sequences,
// then random traffic scored against a behavioural memory/arbitration model.
`timescale 1ns/1ps
module tb_bram_rr_arbiter;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
`ifdef BRAM_ARB_CLEAR_EN
  localparam int unsigned DEPTH = 16;
  localparam int unsigned RBASE = 0;
`else
  localparam int unsigned DEPTH = 131072;
  localparam int unsigned RBASE = 'h100;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic mem_we, clear_busy;

  bram_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
  bram_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

  bram_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .a(a_if), .b(b_if),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  // Bench-side BRAM: registered read-first; unwritten words read as a known pattern
  function automatic logic [DATA_W-1:0] init_val(input int unsigned ad);
    return DATA_W'(ad ^ 32'hA5A5);
  endfunction

  logic [DATA_W-1:0] bram [DEPTH];
  bit                seen [DEPTH];
  int unsigned       ra_i, wa_i;
  assign ra_i = 32'(mem_raddr);
  assign wa_i = 32'(mem_waddr);

  always @(posedge clk) begin
    if (mem_we && wa_i < DEPTH) begin
      bram[wa_i] <= mem_din;
      seen[wa_i] <= 1'b1;
    end
    if (ra_i < DEPTH) mem_dout <= seen[ra_i] ? bram[ra_i] : init_val(ra_i);
    else              mem_dout <= 16'hDEAD;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] ad, input logic br, input logic bw,
                       input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wdata = ad;
    b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wdata = bd;
  endtask

  typedef struct {
    logic a_req, a_we; int a_addr, a_wdata;
    logic b_req, b_we; int b_addr, b_wdata;
    logic e_agnt, e_bgnt, e_we, e_arv; int e_ard;
    logic e_brv; int e_brd;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input int aa, input int ad,
                              input logic br, input logic bw, input int ba, input int bd,
                              input logic ga, input logic gb, input logic we,
                              input logic arv, input int ard, input logic brv, input int brd);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.e_agnt = ga; v.e_bgnt = gb; v.e_we = we;
    v.e_arv = arv; v.e_ard = ard; v.e_brv = brv; v.e_brd = brd;
    return v;
  endfunction

  // Behavioural model state for the random phase
  logic [DATA_W-1:0] ref_mem [int unsigned];
  bit rd_turn_b, wr_turn_b;

  function automatic logic [DATA_W-1:0] model_rd(input int unsigned ad);
    if (ad >= DEPTH) return '0;
    if (ref_mem.exists(ad)) return ref_mem[ad];
`ifdef BRAM_ARB_CLEAR_EN
    return '0;
`else
    return init_val(ad);
`endif
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 8)  return ADDR_W'(RBASE + r);
    if (r == 8) return ADDR_W'(DEPTH - 1);
    return ADDR_W'(DEPTH + 3);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
`ifdef BRAM_ARB_CLEAR_EN
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(negedge clk); #1;
      if (!clear_busy) break;
    end
    chk("clear_wait", 32'(clear_busy), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    logic pa_v, pa_we, pb_v, pb_we;
    logic [ADDR_W-1:0] pa_addr, pb_addr;
    logic [DATA_W-1:0] pa_wd, pb_wd;
    logic ga_r, gb_r, ga_w, gb_w, e_arv, e_brv, e_we;
    logic [DATA_W-1:0] e_ard, e_brd;

    // Reset with requests pending: nothing granted, nothing returned
    reset = 1'b0;
    drive(1, 1, 18'h10, 16'h1234, 1, 0, 18'h20, '0);
    #1;
    chk("rst_a_gnt", 32'(a_if.gnt), 0);
    chk("rst_b_gnt", 32'(b_if.gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_a_rvalid", 32'(a_if.rvalid), 0);
    chk("rst_b_rvalid", 32'(b_if.rvalid), 0);
    chk("rst_a_rdata", 32'(a_if.rdata), 0);
    chk("rst_b_rdata", 32'(b_if.rdata), 0);
`ifdef BRAM_ARB_CLEAR_EN
    chk("rst_clear_busy", 32'(clear_busy), 1);
    drive(1, 0, 18'h3, '0, 1, 0, 18'h5, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("clr_busy", 32'(clear_busy), 1);
      chk("clr_we", 32'(mem_we), 1);
      chk("clr_waddr", 32'(mem_waddr), 32'(i));
      chk("clr_din", 32'(mem_din), 0);
      chk("clr_a_gnt", 32'(a_if.gnt), 0);
      chk("clr_b_gnt", 32'(b_if.gnt), 0);
    end
    @(negedge clk); #1;
    chk("clr_done_busy", 32'(clear_busy), 0);
    chk("clr_first_a_gnt", 32'(a_if.gnt), 1);
    chk("clr_first_b_gnt", 32'(b_if.gnt), 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 1, 0, 18'h5, '0);
    #1;
    chk("clr_b_gnt2", 32'(b_if.gnt), 1);
    chk("clr_a_rvalid", 32'(a_if.rvalid), 1);
    chk("clr_a_rdata", 32'(a_if.rdata), 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    chk("clr_b_rvalid", 32'(b_if.rvalid), 1);
    chk("clr_b_rdata", 32'(b_if.rdata), 0);
`else
    chk("rst_clear_busy", 32'(clear_busy), 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);

    //          A: req we addr      wdata    B: req we addr      wdata    gA gB we  aRv aRd       bRv bRd
    vt[0]  = mk(1, 1, 'h10,    'h1234,  0, 0, 0,        0,       1, 0, 1,  0, 0,        0, 0);
    vt[1]  = mk(1, 0, 'h10,    0,       0, 0, 0,        0,       1, 0, 0,  0, 0,        0, 0);
    vt[2]  = mk(0, 0, 0,       0,       0, 0, 0,        0,       0, 0, 0,  1, 'h1234,   0, 0);
    vt[3]  = mk(1, 0, 'h10,    0,       1, 0, 'h20,     0,       1, 0, 0,  0, 0,        0, 0);
    vt[4]  = mk(1, 0, 'h10,    0,       1, 0, 'h20,     0,       0, 1, 0,  1, 'h1234,   0, 0);
    vt[5]  = mk(1, 0, 'h10,    0,       1, 0, 'h20,     0,       1, 0, 0,  0, 0,        1, 'hA585);
    vt[6]  = mk(0, 0, 0,       0,       1, 0, 'h20,     0,       0, 1, 0,  1, 'h1234,   0, 0);
    vt[7]  = mk(1, 0, 'h30,    0,       1, 1, 'h30,     'hBEEF,  1, 1, 1,  0, 0,        1, 'hA585);
    vt[8]  = mk(1, 0, 'h30,    0,       0, 0, 0,        0,       1, 0, 0,  1, 'hA595,   0, 0);
    vt[9]  = mk(0, 0, 0,       0,       1, 1, DEPTH,    'h5555,  0, 1, 0,  1, 'hBEEF,   0, 0);
    vt[10] = mk(1, 0, DEPTH,   0,       0, 0, 0,        0,       1, 0, 0,  0, 0,        0, 0);
    vt[11] = mk(0, 0, 0,       0,       0, 0, 0,        0,       0, 0, 0,  1, 0,        0, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i].a_req, vt[i].a_we, ADDR_W'(vt[i].a_addr), DATA_W'(vt[i].a_wdata),
            vt[i].b_req, vt[i].b_we, ADDR_W'(vt[i].b_addr), DATA_W'(vt[i].b_wdata));
      #1;
      chk("vec_a_gnt", 32'(a_if.gnt), 32'(vt[i].e_agnt));
      chk("vec_b_gnt", 32'(b_if.gnt), 32'(vt[i].e_bgnt));
      chk("vec_mem_we", 32'(mem_we), 32'(vt[i].e_we));
      chk("vec_a_rvalid", 32'(a_if.rvalid), 32'(vt[i].e_arv));
      chk("vec_b_rvalid", 32'(b_if.rvalid), 32'(vt[i].e_brv));
      if (vt[i].e_arv) chk("vec_a_rdata", 32'(a_if.rdata), 32'(vt[i].e_ard));
      if (vt[i].e_brv) chk("vec_b_rdata", 32'(b_if.rdata), 32'(vt[i].e_brd));
    end

    // Contested write moves the write pointer to B, then a read is killed by reset
    @(negedge clk);
    drive(1, 1, 18'h40, 16'h0001, 1, 1, 18'h50, 16'h0002);
    #1;
    chk("seq_wr_a_wins", 32'(a_if.gnt), 1);
    chk("seq_wr_b_loses", 32'(b_if.gnt), 0);
    @(negedge clk);
    drive(1, 0, 18'h40, '0, 0, 0, '0, '0);
    #1;
    chk("seq_rd_gnt", 32'(a_if.gnt), 1);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 18'h60, 16'h0003, 1, 1, 18'h70, 16'h0004);
    #1;
    chk("seq_rst_rvalid", 32'(a_if.rvalid), 0);
    chk("seq_rst_gnt", 32'(a_if.gnt), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("seq_post_a_rvalid", 32'(a_if.rvalid), 0);
    chk("seq_post_b_rvalid", 32'(b_if.rvalid), 0);
    chk("seq_post_a_gnt", 32'(a_if.gnt), 1);
    chk("seq_post_b_gnt", 32'(b_if.gnt), 0);
`endif

    // Random traffic against the behavioural model
    reset_dut();
    rd_turn_b = 1'b0; wr_turn_b = 1'b0;
    pa_v = 1'b0; pb_v = 1'b0; pa_we = 1'b0; pb_we = 1'b0;
    pa_addr = '0; pb_addr = '0; pa_wd = '0; pb_wd = '0;
    e_arv = 1'b0; e_brv = 1'b0; e_ard = '0; e_brd = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!pa_v && $urandom_range(0, 9) < 7) begin
        pa_v = 1'b1; pa_we = 1'($urandom_range(0, 1)); pa_addr = pick_addr(); pa_wd = DATA_W'($urandom);
      end
      if (!pb_v && $urandom_range(0, 9) < 7) begin
        pb_v = 1'b1; pb_we = 1'($urandom_range(0, 1)); pb_addr = pick_addr(); pb_wd = DATA_W'($urandom);
      end
      drive(pa_v, pa_we, pa_addr, pa_wd, pb_v, pb_we, pb_addr, pb_wd);
      #1;
      ga_r = pa_v & !pa_we; gb_r = pb_v & !pb_we;
      if (ga_r && gb_r) begin
        ga_r = !rd_turn_b; gb_r = rd_turn_b; rd_turn_b = !rd_turn_b;
      end
      ga_w = pa_v & pa_we; gb_w = pb_v & pb_we;
      if (ga_w && gb_w) begin
        ga_w = !wr_turn_b; gb_w = wr_turn_b; wr_turn_b = !wr_turn_b;
      end
      chk("rnd_a_gnt", 32'(a_if.gnt), 32'(ga_r | ga_w));
      chk("rnd_b_gnt", 32'(b_if.gnt), 32'(gb_r | gb_w));
      chk("rnd_a_rvalid", 32'(a_if.rvalid), 32'(e_arv));
      chk("rnd_b_rvalid", 32'(b_if.rvalid), 32'(e_brv));
      if (e_arv) chk("rnd_a_rdata", 32'(a_if.rdata), 32'(e_ard));
      if (e_brv) chk("rnd_b_rdata", 32'(b_if.rdata), 32'(e_brd));
      // Reads see memory contents from before this cycle's write
      e_arv = ga_r; e_ard = ga_r ? model_rd(32'(pa_addr)) : '0;
      e_brv = gb_r; e_brd = gb_r ? model_rd(32'(pb_addr)) : '0;
      e_we = (ga_w && 32'(pa_addr) < DEPTH) || (gb_w && 32'(pb_addr) < DEPTH);
      chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
      if (e_we) begin
        chk("rnd_waddr", 32'(mem_waddr), ga_w ? 32'(pa_addr) : 32'(pb_addr));
        chk("rnd_wdata", 32'(mem_din), ga_w ? 32'(pa_wd) : 32'(pb_wd));
        if (ga_w) ref_mem[32'(pa_addr)] = pa_wd;
        else      ref_mem[32'(pb_addr)] = pb_wd;
      end
      if (ga_r || ga_w) pa_v = 1'b0;
      if (gb_r || gb_w) pb_v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Shares one simple-dual-port block RAM (one read port, one write port, 1-cycle registered read) between two requesters, A and B.
- Each requester issues one read or one write per cycle.
- Reads compete for the read port and writes compete for the write port, using independent round-robin pointers.
- Read data is steered back to the owning requester one cycle later.
- Sits between client logic and the BRAM-inferred memory instance.

Parameters:
- ADDR_W, 17, address width of requesters and memory.
- DATA_W, 16, data word width.
- DEPTH, 131072, number of valid words; addresses >= DEPTH are out of range.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- a_req  input  1  requester A operation valid.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  ADDR_W  requester A address.
- a_wdata  input  DATA_W  requester A write data.
- a_gnt  output  1  A operation accepted this cycle.
- a_rvalid  output  1  A read data valid.
- a_rdata  output  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B.
- mem_raddr  output  ADDR_W  memory read address.
- mem_waddr  output  ADDR_W  memory write address.
- mem_din  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable; the memory writes only when this is 1.
- mem_dout  input  DATA_W  memory registered read data (1 cycle after mem_raddr).
- clear_busy  output  1  initialisation sweep in progress.

Behaviour:
- Reset (reset=0, asynchronous) drives the following; pointers are registered, the rest are held by the reset state:
  - a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, rdata=0, mem_we=0.
  - Read and write round-robin pointers = A.
  - clear_busy=0 (or 1 under the optional feature).
- Grants are combinational in the request cycle. A request is held until granted; the requester must keep addr/wdata stable while req=1 and gnt=0.
- Different ports (A reads while B writes, or vice versa): both granted in the same cycle.
- Same port, both requesting: the requester at the port's pointer wins. The pointer moves to the loser only when a contested grant occurs. An uncontested grant leaves the pointer unchanged.
- Write grant:
  - mem_waddr/mem_din = winner's addr/wdata.
  - mem_we=1, unless addr >= DEPTH; in that case mem_we=0, the write is dropped and gnt is still asserted.
  - mem_we=0 on cycles with no granted write; mem_waddr/mem_din are don't-care.
- Read grant:
  - mem_raddr = winner's addr.
  - An owner tag and an out-of-range flag are registered.
  - Next cycle: owner rvalid=1 and rdata=mem_dout, or rdata=0 if out of range. The other requester's rvalid=0.
  - Read latency is exactly 1 cycle; back-to-back reads give rvalid on consecutive cycles.
- Same-address read and write in one cycle: read returns the old (pre-write) data (read-first).
- rvalid is never suppressed by a later request. The tag for a read granted in the cycle before reset assertion is discarded: no rvalid after reset.
- States:
  - RUN: normal arbitration.
  - CLEAR: only when the optional feature is compiled in.
  - Without the optional feature, reset exits directly to RUN.

Optional Feature:
- Macro BRAM_ARB_CLEAR_EN.
- Defined:
  - Reset enters CLEAR; clear_busy=1; a_gnt=b_gnt=0.
  - A DEPTH-wide counter drives mem_waddr=0,1,...,DEPTH-1 with mem_din=0 and mem_we=1, one word per cycle.
  - After writing DEPTH-1, transition to RUN; clear_busy=0 on the following cycle.
  - Sweep takes exactly DEPTH cycles.
  - Reset mid-sweep restarts the sweep at 0.
- Undefined:
  - No counter or CLEAR state; clear_busy tied 0.
  - Grants are available in the first cycle after reset deassertion.

Test Plan:
- A writes 0x1234 @ 0x00010 while B idle, then A reads 0x00010 -> a_gnt=1 on both ops; mem_we=1 on the write only; a_rvalid=1 with a_rdata=0x1234 one cycle after the read grant.
- A and B both read (0x10, 0x20) for 3 consecutive cycles from reset -> grants A, B, A. rvalid alternates a, b, a with matching data; the loser's request stays held.
- A reads 0x00030 while B writes 0xBEEF @ 0x00030 in the same cycle -> both granted; a_rdata = old value. A re-read next cycle returns 0xBEEF.
- B writes 0x5555 @ address DEPTH (131072, fits in 18 bits with ADDR_W=18 override) -> b_gnt=1, mem_we=0; a read of the same address returns rvalid with rdata=0.
- Assert reset=0 the cycle after a granted read -> no rvalid afterwards; pointers back to A, so a simultaneous A/B write next grants A.
- BRAM_ARB_CLEAR_EN with DEPTH=16 -> clear_busy=1 for 16 cycles; mem_waddr sweeps 0..15 with mem_din=0. Requests held during the sweep are granted on the first RUN cycle, and any read returns 0.
